// File: rtl/deco_pipe.sv
// Pipelined decode stage with integrated register file and a one-deep output register.
// Define DECO_BYPASS_EN to forward same-cycle write-back data into operand reads.
module deco_pipe #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter bit ZERO_R0  = 1'b1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [31:0]                 instr,
    input  logic                        wr_en,
    input  logic [$clog2(NUM_REGS)-1:0] wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [4:0]                  opcode,
    output logic [4:0]                  rd_idx,
    output logic [DATA_W-1:0]           rs_val,
    output logic [DATA_W-1:0]           rt_val,
    output logic [DATA_W-1:0]           imm,
    output logic                        illegal
);

    localparam int ADDR_W = $clog2(NUM_REGS);

    typedef enum logic [4:0] {
        OP_LV   = 5'd1,
        OP_ALU0 = 5'd2,
        OP_ALU1 = 5'd3,
        OP_ALU2 = 5'd4,
        OP_ALU3 = 5'd5,
        OP_CP   = 5'd6,
        OP_B    = 5'd7,
        OP_BEQ  = 5'd8,
        OP_SLR  = 5'd9,
        OP_GP   = 5'd10,
        OP_ALU4 = 5'd12
    } opcode_e;

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic [4:0]        op, fa, fb, fc;
    logic              use_a, use_b, use_c;
    logic [4:0]        d_rd;
    logic [DATA_W-1:0] d_rs, d_rt, d_imm;
    logic              d_illegal;
    logic              accept;

    assign op       = instr[31:27];
    assign fa       = instr[26:22];
    assign fb       = instr[21:17];
    assign fc       = instr[16:12];
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    function automatic logic [DATA_W-1:0] read_reg(input logic [4:0] idx);
        logic [DATA_W-1:0] v;
        v = regs[idx[ADDR_W-1:0]];
`ifdef DECO_BYPASS_EN
        if (wr_en && (5'(wr_addr) == idx)) v = wr_data;
`endif
        if (ZERO_R0 && (idx == 5'd0)) v = '0;
        return v;
    endfunction

    always_comb begin
        use_a     = 1'b0;
        use_b     = 1'b0;
        use_c     = 1'b0;
        d_rd      = '0;
        d_rs      = '0;
        d_rt      = '0;
        d_imm     = '0;
        d_illegal = 1'b0;
        case (op)
            OP_ALU0, OP_ALU1, OP_ALU2, OP_ALU3, OP_ALU4: begin
                use_a = 1'b1; use_b = 1'b1; use_c = 1'b1;
                d_rd  = fa;
                d_rs  = read_reg(fb);
                d_rt  = read_reg(fc);
            end
            OP_LV: begin
                use_a = 1'b1;
                d_rd  = fa;
                d_imm = DATA_W'(instr[21:0]);
            end
            OP_CP: begin
                use_a = 1'b1; use_b = 1'b1;
                d_rd  = fa;
                d_rs  = read_reg(fb);
            end
            OP_B:   d_imm = DATA_W'(instr[21:0]);
            OP_BEQ: begin
                use_a = 1'b1; use_b = 1'b1;
                d_rs  = read_reg(fa);
                d_rt  = read_reg(fb);
                d_imm = DATA_W'(instr[16:0]);
            end
            OP_SLR: begin
                use_a = 1'b1; use_b = 1'b1;
                d_rd  = fa;
                d_rs  = read_reg(fa);
                d_rt  = read_reg(fb);
            end
            OP_GP: begin
                use_b = 1'b1;
                d_rs  = read_reg(fb);
            end
            default: d_illegal = 1'b1;
        endcase
        // Out-of-range register field overrides the decoded fields; only opcode survives.
        if ((use_a && int'(fa) >= NUM_REGS) || (use_b && int'(fb) >= NUM_REGS) ||
            (use_c && int'(fc) >= NUM_REGS)) begin
            d_rd      = '0;
            d_rs      = '0;
            d_rt      = '0;
            d_imm     = '0;
            d_illegal = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            out_valid <= 1'b0;
            opcode    <= '0;
            rd_idx    <= '0;
            rs_val    <= '0;
            rt_val    <= '0;
            imm       <= '0;
            illegal   <= 1'b0;
        end else begin
            if (wr_en && !(ZERO_R0 && (wr_addr == '0))) regs[wr_addr] <= wr_data;
            if (accept) begin
                out_valid <= 1'b1;
                opcode    <= op;
                rd_idx    <= d_rd;
                rs_val    <= d_rs;
                rt_val    <= d_rt;
                imm       <= d_imm;
                illegal   <= d_illegal;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_deco_pipe.sv
// Randomised self-checking bench for deco_pipe (NUM_REGS=8, ZERO_R0=1), against a table-driven decode model.
module tb_deco_pipe;

    localparam int DW = 32;
    localparam int NR = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   instr = '0;
    logic          wr_en = 1'b0;
    logic [2:0]    wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [4:0]    opcode;
    logic [4:0]    rd_idx;
    logic [DW-1:0] rs_val, rt_val, imm;
    logic          illegal;

    deco_pipe #(.DATA_W(DW), .NUM_REGS(NR), .ZERO_R0(1'b1)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode), .rd_idx(rd_idx),
        .rs_val(rs_val), .rt_val(rt_val), .imm(imm), .illegal(illegal)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] im;
        logic        ill;
    } bundle_t;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] mregs [NR];
    bundle_t     exp_b;
    logic        exp_valid;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [31:0] mk(input int op, input int a, input int b, input int c, input int lo);
        logic [31:0] w;
        w = {op[4:0], a[4:0], b[4:0], c[4:0], lo[11:0]};
        return w;
    endfunction

    function automatic logic [31:0] mread(input logic [4:0] idx, input logic we,
                                          input logic [2:0] wa, input logic [31:0] wd);
        if (idx == 0 || idx >= NR) return 32'd0;
`ifdef DECO_BYPASS_EN
        if (we && idx == {2'b00, wa}) return wd;
`endif
        return mregs[idx[2:0]];
    endfunction

    function automatic bundle_t model_decode(input logic [31:0] ins, input logic we,
                                             input logic [2:0] wa, input logic [31:0] wd);
        bundle_t b;
        logic [4:0] op, a, bf, c;
        bit ua, ub, uc;
        b = '0;
        op = ins[31:27]; a = ins[26:22]; bf = ins[21:17]; c = ins[16:12];
        ua = 0; ub = 0; uc = 0;
        b.op = op;
        case (op)
            2, 3, 4, 5, 12: begin
                ua = 1; ub = 1; uc = 1;
                b.rd = a; b.rs = mread(bf, we, wa, wd); b.rt = mread(c, we, wa, wd);
            end
            1:  begin ua = 1; b.rd = a; b.im = {10'd0, ins[21:0]}; end
            6:  begin ua = 1; ub = 1; b.rd = a; b.rs = mread(bf, we, wa, wd); end
            7:  b.im = {10'd0, ins[21:0]};
            8:  begin ua = 1; ub = 1; b.rs = mread(a, we, wa, wd); b.rt = mread(bf, we, wa, wd);
                      b.im = {15'd0, ins[16:0]}; end
            9:  begin ua = 1; ub = 1; b.rd = a; b.rs = mread(a, we, wa, wd); b.rt = mread(bf, we, wa, wd); end
            10: begin ub = 1; b.rs = mread(bf, we, wa, wd); end
            default: b.ill = 1;
        endcase
        if ((ua && a >= NR) || (ub && bf >= NR) || (uc && c >= NR)) begin
            b = '0; b.op = op; b.ill = 1;
        end
        return b;
    endfunction

    task automatic check_outputs();
        check("out_valid", out_valid, exp_valid);
        if (exp_valid) begin
            check("opcode", opcode, exp_b.op);
            check("rd_idx", rd_idx, exp_b.rd);
            check("rs_val", rs_val, exp_b.rs);
            check("rt_val", rt_val, exp_b.rt);
            check("imm", imm, exp_b.im);
            check("illegal", illegal, exp_b.ill);
        end
    endtask

    // Called #1 after a rising edge; leaves the bench #1 after the next rising edge.
    task automatic cycle(input logic iv, input logic [31:0] ins, input logic ordy,
                         input logic we, input logic [2:0] wa, input logic [31:0] wd);
        bundle_t nb;
        logic acc;
        in_valid = iv; instr = ins; out_ready = ordy;
        wr_en = we; wr_addr = wa; wr_data = wd;
        #1;
        check("in_ready", in_ready, !exp_valid || ordy);
        acc = iv && (!exp_valid || ordy);
        nb = model_decode(ins, we, wa, wd);
        @(posedge clock);
        if (we && wa != 0) mregs[wa] = wd;
        if (acc) begin
            exp_b = nb; exp_valid = 1'b1;
        end else if (ordy) begin
            exp_valid = 1'b0;
        end
        #1;
        check_outputs();
    endtask

    task automatic do_reset(input logic iv, input logic we, input logic [2:0] wa);
        reset = 1'b1; in_valid = iv; instr = mk(2, 1, 2, 3, 0); out_ready = 1'b0;
        wr_en = we; wr_addr = wa; wr_data = 32'hDEAD_BEEF;
        @(posedge clock);
        #1;
        reset = 1'b0; wr_en = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < NR; i++) mregs[i] = '0;
        exp_valid = 1'b0; exp_b = '0;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_opcode", opcode, 5'd0);
        check("rst_rd_idx", rd_idx, 5'd0);
        check("rst_rs_val", rs_val, 32'd0);
        check("rst_rt_val", rt_val, 32'd0);
        check("rst_imm", imm, 32'd0);
        check("rst_illegal", illegal, 1'b0);
        #1;
        check("rst_in_ready", in_ready, 1'b1);
    endtask

    function automatic int rfield();
        return ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 31)) : int'($urandom_range(0, 7));
    endfunction

    initial begin
        for (int i = 0; i < NR; i++) mregs[i] = '0;
        exp_valid = 1'b0; exp_b = '0;
        repeat (2) @(posedge clock);
        #1;
        do_reset(1'b1, 1'b1, 3'd5);
        #1 ;
        @(posedge clock); #1;

        cycle(1, mk(2, 5, 3, 4, 0), 1, 0, 0, 0);
        check("add_zero_rs", rs_val, 32'd0);
        cycle(0, 0, 1, 1, 3, 32'h11);
        cycle(0, 0, 1, 1, 4, 32'h22);
        cycle(1, mk(2, 5, 3, 4, 0), 1, 0, 0, 0);
        check("add_rd", rd_idx, 5'd5);
        check("add_rs", rs_val, 32'h11);
        check("add_rt", rt_val, 32'h22);

        cycle(1, mk(6, 1, 7, 0, 0), 1, 1, 7, 32'hAB);
`ifdef DECO_BYPASS_EN
        check("cp_bypass", rs_val, 32'hAB);
`else
        check("cp_nobypass", rs_val, 32'h0);
`endif

        cycle(1, mk(2, 1, 3, 4, 0), 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) cycle(1, mk(9, 3, 4, 0, k), 0, 1, 3, 32'h99 + k);
        check("stall_in_ready", in_ready, 1'b0);
        cycle(1, mk(9, 3, 4, 0, 7), 1, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0);

        cycle(1, mk(2, 1, 2, 9, 0), 1, 0, 0, 0);
        check("range_illegal", illegal, 1'b1);
        cycle(1, mk(13, 3, 4, 5, 12'hFFF), 1, 0, 0, 0);
        check("op13_illegal", illegal, 1'b1);
        check("op13_opcode", opcode, 5'd13);
        cycle(0, 0, 1, 1, 0, 32'h55);
        cycle(1, mk(10, 0, 0, 0, 0), 1, 0, 0, 0);
        check("r0_zero", rs_val, 32'd0);

        cycle(0, 0, 1, 1, 2, 32'h77);
        cycle(1, mk(6, 1, 2, 0, 0), 0, 0, 0, 0);
        check("pre_rst_valid", out_valid, 1'b1);
        do_reset(1'b1, 1'b1, 3'd2);
        cycle(1, mk(6, 1, 2, 0, 0), 1, 0, 0, 0);
        check("post_rst_r2", rs_val, 32'd0);

        for (int n = 0; n < 3000; n++) begin
            int op;
            logic [31:0] w;
            op = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31))
                                              : int'($urandom_range(1, 12));
            w = mk(op, rfield(), rfield(), rfield(), int'($urandom_range(0, 4095)));
            cycle($urandom_range(0, 3) != 0, w, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/deco_pipe.md
# deco_pipe

Parametrised, pipelined decode stage with integrated register file for the team's 5-bit-opcode processor. It accepts one 32-bit instruction per cycle over a valid/ready handshake and extracts the fields per instruction format. It reads up to two source registers and presents a registered decode bundle to the execute stage. One synchronous write-back port updates the register file; an optional bypass forwards same-cycle write-back data to the operand reads.

## Interface
Parameters:
- DATA_W, 32: register and operand width (8..64).
- NUM_REGS, 32: register count; legal values are 8, 16 and 32. ADDR_W = $clog2(NUM_REGS).
- ZERO_R0, 1: when 1, register 0 reads as 0 and writes to it are discarded.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  instruction present.
- in_ready  out  1  stage can accept this cycle.
- instr  in  32  instruction word.
- wr_en  in  1  write-back strobe.
- wr_addr  in  ADDR_W  write-back register index.
- wr_data  in  DATA_W  write-back value.
- out_valid  out  1  decode bundle valid.
- out_ready  in  1  execute stage accepts bundle.
- opcode  out  5  instr[31:27].
- rd_idx  out  5  destination index, or 0.
- rs_val, rt_val  out  DATA_W  operand values.
- imm  out  DATA_W  zero-extended immediate.
- illegal  out  1  undefined opcode or out-of-range register field.

## Operation
- Fields: A = instr[26:22], B = instr[21:17], C = instr[16:12].
- Any used field with a value >= NUM_REGS sets illegal=1 and zeroes the other outputs except opcode.
- Decode by opcode. Unused outputs are 0.
  - 2,3,4,5,12 (arith): rd_idx=A, rs_val=R[B], rt_val=R[C].
  - 1 (LV): rd_idx=A, imm=instr[21:0].
  - 6 (CP): rd_idx=A, rs_val=R[B].
  - 7 (B): imm=instr[21:0].
  - 8 (BEQ): rs_val=R[A], rt_val=R[B], imm=instr[16:0].
  - 9 (SLR): rd_idx=A, rs_val=R[A], rt_val=R[B].
  - 10 (GP): rs_val=R[B].
  - 0, 11, 13..31: illegal=1, all other outputs 0 except opcode.
- Register file: NUM_REGS x DATA_W flops. On wr_en at the clock edge, R[wr_addr] <= wr_data. With ZERO_R0=1, writes to R0 are ignored.
- Reset clears all registers to 0.
- Handshake: in_ready = !out_valid || out_ready.
  - Accept happens when in_valid && in_ready.
  - On accept, the bundle is registered and out_valid=1.
  - out_valid clears when out_ready is high and no new accept occurs.
- While stalled (out_valid && !out_ready), the bundle holds constant, including operand values. A write to a source register during the stall does not refresh the held bundle; hazard handling is upstream's responsibility.

## Timing
- Latency: 1 cycle from accept to out_valid. Throughput: 1 instruction per cycle when out_ready stays high.
- Reset values: out_valid=0; opcode, rd_idx, rs_val, rt_val, imm and illegal all 0; every register 0. in_ready=1 in the cycle after reset.
- Write and read of the same register in the same cycle: the operand value depends on DECO_BYPASS_EN (see Configuration).
- Reset asserted mid-operation: the in-flight bundle is dropped, and any wr_en in that cycle is ignored.
- Simultaneous drain and accept (out_valid && out_ready && in_valid): the new bundle replaces the old one and out_valid stays 1.

## Configuration
- DECO_BYPASS_EN defined: when wr_en is high and wr_addr equals a source index being read in the accept cycle, the operand takes wr_data. The R0 rule still applies when ZERO_R0=1.
- DECO_BYPASS_EN undefined: operands read the pre-edge register contents. A same-cycle write becomes visible to instructions accepted on the following cycle.

## Test plan
- Reset, then idle: out_valid=0, all outputs 0, in_ready=1. Decoding opcode 2 with B=3, C=4 gives rs_val=0, rt_val=0.
- Write R3=0x11 and R4=0x22, then decode ADD (opcode 2, A=5, B=3, C=4): one cycle later out_valid=1, rd_idx=5, rs_val=0x11, rt_val=0x22.
- wr_en with R7=0xAB in the same cycle as accepting CP (A=1, B=7): rs_val=0xAB with DECO_BYPASS_EN, and the old value 0 without it.
- Hold out_ready=0 for 3 cycles with in_valid high: in_ready=0 and the bundle stays constant. Raise out_ready: the next instruction appears one cycle later with no loss and no duplication.
- NUM_REGS=8: decoding ADD with C=9 gives illegal=1. Opcode 13 gives illegal=1 with all other outputs 0 except opcode. Write to R0 with ZERO_R0=1, then GP B=0: rs_val=0.
- Assert reset while out_valid=1 and out_ready=0: the next cycle shows out_valid=0 and registers cleared.
